// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/decode/execute sequencer for the Datapath
module control_unit #(
  parameter logic [4:0] OP_ADD  = 5'b00011,
  parameter logic [4:0] OP_SUB  = 5'b00100,
  parameter logic [4:0] OP_AND  = 5'b00101,
  parameter logic [4:0] OP_OR   = 5'b00110,
  parameter logic [4:0] OP_BR   = 5'b10010,
  parameter logic [4:0] OP_IN   = 5'b10110,
  parameter logic [4:0] OP_OUT  = 5'b10111,
  parameter logic [4:0] OP_NOP  = 5'b11010,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] opcode,
  input  logic       CON_FF,
  input  logic       stop,
  output logic       run,
  output logic       PCout,
  output logic       MAR_enable,
  output logic       IncPC,
  output logic       Z_enable,
  output logic       MDR_enable,
  output logic       ZLowout,
  output logic       PC_enable,
  output logic       MDRout,
  output logic       IR_enable,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rout,
  output logic       R_enable,
  output logic       Y_enable,
  output logic       Cout,
  output logic       CON_enable,
  output logic       InPortout,
  output logic       OutPort_enable,
  output logic       RAM_write,
  output logic [2:0] MDR_read
);

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_T0     = 4'd1;
  localparam logic [3:0] S_T1     = 4'd2;
  localparam logic [3:0] S_T2     = 4'd3;
  localparam logic [3:0] S_DECODE = 4'd4;
  localparam logic [3:0] S_ALU_T3 = 4'd5;
  localparam logic [3:0] S_ALU_T4 = 4'd6;
  localparam logic [3:0] S_ALU_T5 = 4'd7;
  localparam logic [3:0] S_BR_T3  = 4'd8;
  localparam logic [3:0] S_BR_T4  = 4'd9;
  localparam logic [3:0] S_BR_T5  = 4'd10;
  localparam logic [3:0] S_BR_T6  = 4'd11;
  localparam logic [3:0] S_IN_T3  = 4'd12;
  localparam logic [3:0] S_OUT_T3 = 4'd13;
  localparam logic [3:0] S_HALT   = 4'd14;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] boundary_next;

  // Next-state logic; boundary states go to HALT when stop is requested, else start a new fetch
  always_comb begin
    boundary_next = stop ? S_HALT : S_T0;
    state_d       = state_q;
    case (state_q)
      S_RESET:  state_d = boundary_next;
      S_T0:     state_d = S_T1;
      S_T1:     state_d = S_T2;
      S_T2:     state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_ALU_T3;
          OP_BR:   state_d = S_BR_T3;
          OP_IN:   state_d = S_IN_T3;
          OP_OUT:  state_d = S_OUT_T3;
          OP_HALT: state_d = S_HALT;
          OP_NOP:  state_d = boundary_next;
          default: state_d = boundary_next;
        endcase
      end
      S_ALU_T3: state_d = S_ALU_T4;
      S_ALU_T4: state_d = S_ALU_T5;
      S_ALU_T5: state_d = boundary_next;
      S_BR_T3:  state_d = S_BR_T4;
      S_BR_T4:  state_d = S_BR_T5;
      S_BR_T5:  state_d = S_BR_T6;
      S_BR_T6:  state_d = boundary_next;
      S_IN_T3:  state_d = boundary_next;
      S_OUT_T3: state_d = boundary_next;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RESET;
    endcase
  end

  // State register; clr overrides any transition, including mid-instruction
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore strobe decode; only the branch PC load looks at an input (CON_FF)
  always_comb begin
    run            = 1'b1;
    PCout          = 1'b0;
    MAR_enable     = 1'b0;
    IncPC          = 1'b0;
    Z_enable       = 1'b0;
    MDR_enable     = 1'b0;
    ZLowout        = 1'b0;
    PC_enable      = 1'b0;
    MDRout         = 1'b0;
    IR_enable      = 1'b0;
    Gra            = 1'b0;
    Grb            = 1'b0;
    Grc            = 1'b0;
    Rout           = 1'b0;
    R_enable       = 1'b0;
    Y_enable       = 1'b0;
    Cout           = 1'b0;
    CON_enable     = 1'b0;
    InPortout      = 1'b0;
    OutPort_enable = 1'b0;
    RAM_write      = 1'b0;
    MDR_read       = 3'd0;
    case (state_q)
      S_RESET: run = 1'b0;
      S_T0: begin
        PCout      = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        Z_enable   = 1'b1;
      end
      S_T1: begin
        ZLowout    = 1'b1;
        PC_enable  = 1'b1;
        MDR_enable = 1'b1;
        MDR_read   = 3'd1;
      end
      S_T2: begin
        MDRout    = 1'b1;
        IR_enable = 1'b1;
      end
      S_ALU_T3: begin
        Grb      = 1'b1;
        Rout     = 1'b1;
        Y_enable = 1'b1;
      end
      S_ALU_T4: begin
        Grc      = 1'b1;
        Rout     = 1'b1;
        Z_enable = 1'b1;
      end
      S_ALU_T5: begin
        ZLowout  = 1'b1;
        Gra      = 1'b1;
        R_enable = 1'b1;
      end
      S_BR_T3: begin
        Gra        = 1'b1;
        Rout       = 1'b1;
        CON_enable = 1'b1;
      end
      S_BR_T4: begin
        PCout    = 1'b1;
        Y_enable = 1'b1;
      end
      S_BR_T5: begin
        Cout     = 1'b1;
        Z_enable = 1'b1;
      end
      S_BR_T6: begin
        ZLowout   = 1'b1;
        PC_enable = CON_FF;
      end
      S_IN_T3: begin
        InPortout = 1'b1;
        Gra       = 1'b1;
        R_enable  = 1'b1;
      end
      S_OUT_T3: begin
        Gra            = 1'b1;
        Rout           = 1'b1;
        OutPort_enable = 1'b1;
      end
      S_HALT:  run = 1'b0;
      S_DECODE: run = 1'b1;
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  logic       clk;
  logic       clr;
  logic [4:0] opcode;
  logic       CON_FF;
  logic       stop;
  logic       run;
  logic       PCout, MAR_enable, IncPC, Z_enable, MDR_enable, ZLowout, PC_enable;
  logic       MDRout, IR_enable, Gra, Grb, Grc, Rout, R_enable, Y_enable, Cout;
  logic       CON_enable, InPortout, OutPort_enable, RAM_write;
  logic [2:0] MDR_read;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] C_ADD  = 5'b00011;
  localparam logic [4:0] C_SUB  = 5'b00100;
  localparam logic [4:0] C_AND  = 5'b00101;
  localparam logic [4:0] C_OR   = 5'b00110;
  localparam logic [4:0] C_BR   = 5'b10010;
  localparam logic [4:0] C_IN   = 5'b10110;
  localparam logic [4:0] C_OUT  = 5'b10111;
  localparam logic [4:0] C_NOP  = 5'b11010;
  localparam logic [4:0] C_HALT = 5'b11011;
  localparam logic [4:0] C_UNK  = 5'b00000;

  localparam logic [19:0] B_PCOUT  = 20'd1 << 19;
  localparam logic [19:0] B_MAR    = 20'd1 << 18;
  localparam logic [19:0] B_INCPC  = 20'd1 << 17;
  localparam logic [19:0] B_ZEN    = 20'd1 << 16;
  localparam logic [19:0] B_MDREN  = 20'd1 << 15;
  localparam logic [19:0] B_ZLOW   = 20'd1 << 14;
  localparam logic [19:0] B_PCEN   = 20'd1 << 13;
  localparam logic [19:0] B_MDROUT = 20'd1 << 12;
  localparam logic [19:0] B_IREN   = 20'd1 << 11;
  localparam logic [19:0] B_GRA    = 20'd1 << 10;
  localparam logic [19:0] B_GRB    = 20'd1 << 9;
  localparam logic [19:0] B_GRC    = 20'd1 << 8;
  localparam logic [19:0] B_ROUT   = 20'd1 << 7;
  localparam logic [19:0] B_REN    = 20'd1 << 6;
  localparam logic [19:0] B_YEN    = 20'd1 << 5;
  localparam logic [19:0] B_COUT   = 20'd1 << 4;
  localparam logic [19:0] B_CONEN  = 20'd1 << 3;
  localparam logic [19:0] B_INPORT = 20'd1 << 2;
  localparam logic [19:0] B_OUTEN  = 20'd1 << 1;

  localparam logic [19:0] E_NONE = 20'd0;
  localparam logic [19:0] E_T0   = B_PCOUT | B_MAR | B_INCPC | B_ZEN;
  localparam logic [19:0] E_T1   = B_ZLOW | B_PCEN | B_MDREN;
  localparam logic [19:0] E_T2   = B_MDROUT | B_IREN;
  localparam logic [19:0] E_A3   = B_GRB | B_ROUT | B_YEN;
  localparam logic [19:0] E_A4   = B_GRC | B_ROUT | B_ZEN;
  localparam logic [19:0] E_A5   = B_ZLOW | B_GRA | B_REN;
  localparam logic [19:0] E_B3   = B_GRA | B_ROUT | B_CONEN;
  localparam logic [19:0] E_B4   = B_PCOUT | B_YEN;
  localparam logic [19:0] E_B5   = B_COUT | B_ZEN;
  localparam logic [19:0] E_B6N  = B_ZLOW;
  localparam logic [19:0] E_B6T  = B_ZLOW | B_PCEN;
  localparam logic [19:0] E_IN   = B_INPORT | B_GRA | B_REN;
  localparam logic [19:0] E_OUT  = B_GRA | B_ROUT | B_OUTEN;

  logic [23:0] obs;
  assign obs = {PCout, MAR_enable, IncPC, Z_enable, MDR_enable, ZLowout, PC_enable,
                MDRout, IR_enable, Gra, Grb, Grc, Rout, R_enable, Y_enable, Cout,
                CON_enable, InPortout, OutPort_enable, RAM_write, MDR_read, run};

  control_unit dut (
    .clk(clk), .clr(clr), .opcode(opcode), .CON_FF(CON_FF), .stop(stop), .run(run),
    .PCout(PCout), .MAR_enable(MAR_enable), .IncPC(IncPC), .Z_enable(Z_enable),
    .MDR_enable(MDR_enable), .ZLowout(ZLowout), .PC_enable(PC_enable), .MDRout(MDRout),
    .IR_enable(IR_enable), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout),
    .R_enable(R_enable), .Y_enable(Y_enable), .Cout(Cout), .CON_enable(CON_enable),
    .InPortout(InPortout), .OutPort_enable(OutPort_enable), .RAM_write(RAM_write),
    .MDR_read(MDR_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] s, input logic [2:0] m, input logic r);
    logic [23:0] exp;
    exp = {s, m, r};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks T0..T2 from T0, loads the opcode, and leaves the FSM in DECODE
  task automatic fetch(input logic [4:0] op, input string tag);
    chk({tag, "_t0"}, E_T0, 3'd0, 1'b1);
    step();
    chk({tag, "_t1"}, E_T1, 3'd1, 1'b1);
    step();
    chk({tag, "_t2"}, E_T2, 3'd0, 1'b1);
    opcode = op;
    step();
    chk({tag, "_dec"}, E_NONE, 3'd0, 1'b1);
  endtask

  task automatic alu_exec(input string tag);
    step();
    chk({tag, "_a3"}, E_A3, 3'd0, 1'b1);
    opcode = C_BR;
    step();
    chk({tag, "_a4"}, E_A4, 3'd0, 1'b1);
    step();
    chk({tag, "_a5"}, E_A5, 3'd0, 1'b1);
    step();
  endtask

  initial begin
    clr = 1'b1; opcode = 5'd0; CON_FF = 1'b0; stop = 1'b0;
    step();
    chk("rst_hold0", E_NONE, 3'd0, 1'b0);
    step();
    chk("rst_hold1", E_NONE, 3'd0, 1'b0);
    clr = 1'b0;
    chk("rst_release", E_NONE, 3'd0, 1'b0);
    step();

    fetch(C_ADD, "add");
    alu_exec("add");
    fetch(C_SUB, "sub");
    alu_exec("sub");
    fetch(C_AND, "and");
    alu_exec("and");
    fetch(C_OR, "or");
    alu_exec("or");

    CON_FF = 1'b1;
    fetch(C_BR, "brt");
    step(); chk("brt_b3", E_B3, 3'd0, 1'b1);
    step(); chk("brt_b4", E_B4, 3'd0, 1'b1);
    step(); chk("brt_b5", E_B5, 3'd0, 1'b1);
    step(); chk("brt_b6", E_B6T, 3'd0, 1'b1);
    step();

    fetch(C_BR, "brn");
    step(); chk("brn_b3", E_B3, 3'd0, 1'b1);
    step(); chk("brn_b4", E_B4, 3'd0, 1'b1);
    step(); chk("brn_b5", E_B5, 3'd0, 1'b1);
    CON_FF = 1'b0;
    step(); chk("brn_b6", E_B6N, 3'd0, 1'b1);
    step();

    fetch(C_IN, "in");
    step(); chk("in_t3", E_IN, 3'd0, 1'b1);
    step();
    fetch(C_OUT, "out");
    step(); chk("out_t3", E_OUT, 3'd0, 1'b1);
    step();
    fetch(C_NOP, "nop");
    step();
    fetch(C_UNK, "unk");
    step();
    chk("unk_next_t0", E_T0, 3'd0, 1'b1);

    fetch(C_ADD, "stp");
    step(); chk("stp_a3", E_A3, 3'd0, 1'b1);
    step(); chk("stp_a4", E_A4, 3'd0, 1'b1);
    stop = 1'b1;
    step(); chk("stp_a5", E_A5, 3'd0, 1'b1);
    step(); chk("stp_halt", E_NONE, 3'd0, 1'b0);
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); chk("stp_halt_hold", E_NONE, 3'd0, 1'b0);
    end

    clr = 1'b1;
    step(); chk("hclr_reset", E_NONE, 3'd0, 1'b0);
    clr = 1'b0;
    step();
    fetch(C_HALT, "hlt");
    for (int i = 0; i < 10; i++) begin
      step(); chk("hlt_hold", E_NONE, 3'd0, 1'b0);
    end

    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    fetch(C_BR, "brclr");
    step(); chk("brclr_b3", E_B3, 3'd0, 1'b1);
    step(); chk("brclr_b4", E_B4, 3'd0, 1'b1);
    clr = 1'b1;
    step(); chk("brclr_reset", E_NONE, 3'd0, 1'b0);
    clr = 1'b0;
    step(); chk("brclr_t0", E_T0, 3'd0, 1'b1);

    clr = 1'b1;
    step();
    clr = 1'b0;
    stop = 1'b1;
    step(); chk("rst_stop_halt", E_NONE, 3'd0, 1'b0);
    stop = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    fetch(C_NOP, "nopstp");
    stop = 1'b1;
    step(); chk("nopstp_halt", E_NONE, 3'd0, 1'b0);
    stop = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
